// File: rtl/ttes_counter_unit_if.sv
// Control and status bundle for ttes_counter_unit.
// The counter is the slave side; the master drives the controls and observes the status.
`timescale 1ns/1ps
interface ttes_counter_unit_if #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
);
    logic             en_i;
    logic             clr_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic             dir_i;
    logic [1:0]       mode_i;
    logic [PSC_W-1:0] prescale_i;
    logic [WIDTH-1:0] cmp_val_i;
    logic             ovf_clr_i;
    logic [WIDTH-1:0] count_o;
    logic             tick_o;
    logic             match_o;
    logic             tc_o;
    logic             ovf_sticky_o;
    logic             running_o;

    modport master (
        output en_i, clr_i, load_i, load_val_i, dir_i, mode_i, prescale_i, cmp_val_i, ovf_clr_i,
        input  count_o, tick_o, match_o, tc_o, ovf_sticky_o, running_o
    );

    modport slave (
        input  en_i, clr_i, load_i, load_val_i, dir_i, mode_i, prescale_i, cmp_val_i, ovf_clr_i,
        output count_o, tick_o, match_o, tc_o, ovf_sticky_o, running_o
    );
endinterface

// File: rtl/ttes_counter_unit.sv
// General-purpose up/down counter with prescaler, wrap/saturate/one-shot modes,
// synchronous clear/load and registered tick/match/tc pulses plus a sticky overflow flag.
`timescale 1ns/1ps
module ttes_counter_unit #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    ttes_counter_unit_if.slave  cnt_if
);
    localparam logic [1:0]       MODE_SAT     = 2'b01;
    localparam logic [1:0]       MODE_ONESHOT = 2'b10;
    localparam logic [WIDTH-1:0] CNT_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PSC_W-1:0] PSC_ONE      = {{(PSC_W-1){1'b0}}, 1'b1};

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             tick_q, tick_d;
    logic             match_q, match_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             step_req;
    logic             at_term;
    logic [WIDTH-1:0] stepped;

    // >= rather than == so a prescale lowered below the running psc still fires.
    assign step_req = cnt_if.en_i && (psc_q >= cnt_if.prescale_i);
    assign at_term  = cnt_if.dir_i ? (count_q == '0) : (count_q == '1);
    // Natural modular +/-1 gives the wrap value at the terminal count.
    assign stepped  = cnt_if.dir_i ? (count_q - CNT_ONE) : (count_q + CNT_ONE);

    // NOTE: async reset only on the state registers; everything else is next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            count_q <= '0;
            psc_q   <= '0;
            tick_q  <= 1'b0;
            match_q <= 1'b0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            psc_q   <= psc_d;
            tick_q  <= tick_d;
            match_q <= match_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        psc_d   = psc_q;
        tick_d  = 1'b0;
        match_d = 1'b0;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;

        if (cnt_if.en_i) begin
            psc_d = step_req ? '0 : (psc_q + PSC_ONE);
        end

        if (cnt_if.clr_i) begin
            state_d = ST_RUN;
            count_d = '0;
            psc_d   = '0;
            ovf_d   = 1'b0;
        end else if (cnt_if.load_i) begin
            state_d = ST_RUN;
            count_d = cnt_if.load_val_i;
            psc_d   = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (step_req) begin
                        if (!at_term) begin
                            count_d = stepped;
                            tick_d  = 1'b1;
                            match_d = (stepped == cnt_if.cmp_val_i);
                        end else if (cnt_if.mode_i == MODE_SAT) begin
                            tc_d = 1'b1;
                        end else if (cnt_if.mode_i == MODE_ONESHOT) begin
                            tc_d    = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            count_d = stepped;
                            tick_d  = 1'b1;
                            tc_d    = 1'b1;
                            match_d = (stepped == cnt_if.cmp_val_i);
                        end
                    end
                end
                ST_HALT: begin
                    if (cnt_if.mode_i != MODE_ONESHOT) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        // A tc on the same edge as ovf_clr leaves the flag set.
        if (!cnt_if.clr_i) begin
            if (cnt_if.ovf_clr_i) ovf_d = 1'b0;
            if (tc_d)             ovf_d = 1'b1;
        end
    end

    assign cnt_if.count_o      = count_q;
    assign cnt_if.tick_o       = tick_q;
    assign cnt_if.match_o      = match_q;
    assign cnt_if.tc_o         = tc_q;
    assign cnt_if.ovf_sticky_o = ovf_q;
    assign cnt_if.running_o    = (state_q == ST_RUN);
endmodule

// File: tb/tb_ttes_counter_unit.sv
// Scoreboard bench for ttes_counter_unit: a behavioural model predicts each post-edge
// output set into a queue, and an independent monitor pops and compares after every edge.
`timescale 1ns/1ps
module tb_ttes_counter_unit;
    localparam int W = 8;
    localparam int P = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ttes_counter_unit_if #(.WIDTH(W), .PSC_W(P)) cnt_if ();

    ttes_counter_unit #(.WIDTH(W), .PSC_W(P)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt_if (cnt_if.slave)
    );

    typedef struct packed {
        logic [W-1:0] count;
        logic         tick;
        logic         match;
        logic         tc;
        logic         ovf;
        logic         run;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int m_count;
    int m_psc;
    bit m_ovf;
    bit m_run;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.count = cnt_if.count_o;
        o.tick  = cnt_if.tick_o;
        o.match = cnt_if.match_o;
        o.tc    = cnt_if.tc_o;
        o.ovf   = cnt_if.ovf_sticky_o;
        o.run   = cnt_if.running_o;
        return o;
    endfunction

    task automatic model_reset();
        m_count = 0; m_psc = 0; m_ovf = 0; m_run = 1;
    endtask

    // Predict the outputs after the coming edge from the inputs currently applied.
    task automatic model_edge();
        obs_t e;
        bit   step;
        bit   at_term;
        e = '0;
        step = cnt_if.en_i && (m_psc >= int'(cnt_if.prescale_i));
        if (cnt_if.clr_i) begin
            m_count = 0; m_psc = 0; m_ovf = 0; m_run = 1;
        end else if (cnt_if.load_i) begin
            m_count = int'(cnt_if.load_val_i); m_psc = 0; m_run = 1;
            if (cnt_if.ovf_clr_i) m_ovf = 0;
        end else begin
            if (cnt_if.en_i) m_psc = step ? 0 : m_psc + 1;
            if (!m_run) begin
                if (cnt_if.mode_i != 2'd2) m_run = 1;
            end else if (step) begin
                at_term = cnt_if.dir_i ? (m_count == 0) : (m_count == MAXV);
                if (!at_term) begin
                    m_count = cnt_if.dir_i ? m_count - 1 : m_count + 1;
                    e.tick = 1; e.match = (m_count == int'(cnt_if.cmp_val_i));
                end else if (cnt_if.mode_i == 2'd1) begin
                    e.tc = 1;
                end else if (cnt_if.mode_i == 2'd2) begin
                    e.tc = 1; m_run = 0;
                end else begin
                    m_count = cnt_if.dir_i ? MAXV : 0;
                    e.tick = 1; e.tc = 1; e.match = (m_count == int'(cnt_if.cmp_val_i));
                end
            end
            if (cnt_if.ovf_clr_i) m_ovf = 0;
            if (e.tc) m_ovf = 1;
        end
        e.count = m_count[W-1:0];
        e.ovf   = m_ovf;
        e.run   = m_run;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic load_val(input int v);
        cnt_if.load_i = 1'b1; cnt_if.load_val_i = v[W-1:0];
        cycles(1);
        cnt_if.load_i = 1'b0;
    endtask

    // Monitor: every edge the DUT presents a fresh output set; compare with the oldest prediction.
    always @(posedge clk) begin
        obs_t want;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("cycle_outputs", 64'(sample()), 64'(want));
        end
    end

    initial begin
        obs_t rst_exp;
        cnt_if.en_i = 0; cnt_if.clr_i = 0; cnt_if.load_i = 0; cnt_if.load_val_i = '0;
        cnt_if.dir_i = 0; cnt_if.mode_i = 2'd0; cnt_if.prescale_i = '0;
        cnt_if.cmp_val_i = 8'hAA; cnt_if.ovf_clr_i = 0;
        rst_exp = '0; rst_exp.run = 1'b1;
        model_reset();

        #1 check("reset_state", 64'(sample()), 64'(rst_exp));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Free-running wrap through 255->0, then clear the sticky flag
        cnt_if.en_i = 1;
        cycles(258);
        cnt_if.ovf_clr_i = 1; cycles(1); cnt_if.ovf_clr_i = 0;

        // Prescaler of 4 with an enable gap mid-period
        cnt_if.clr_i = 1; cycles(1); cnt_if.clr_i = 0;
        cnt_if.prescale_i = 4'd3;
        cycles(10);
        cnt_if.en_i = 0; cycles(2); cnt_if.en_i = 1;
        cycles(10);

        // Saturate counting down onto 0
        cnt_if.prescale_i = 4'd0; cnt_if.mode_i = 2'd1; cnt_if.dir_i = 1;
        load_val(3);
        cycles(6);

        // One-shot up from 250, halt, then reload
        cnt_if.mode_i = 2'd2; cnt_if.dir_i = 0;
        load_val(250);
        cycles(17);
        load_val(10);
        cycles(3);

        // Compare match going up, no match on load, match again after wrapping
        cnt_if.mode_i = 2'd0; cnt_if.cmp_val_i = 8'h10;
        load_val(8'h0C);
        cycles(6);
        load_val(8'h10);
        cycles(260);

        // Same-edge clr + load + step request
        cnt_if.clr_i = 1; cnt_if.load_i = 1; cnt_if.load_val_i = 8'h77;
        cycles(1);
        cnt_if.clr_i = 0; cnt_if.load_i = 0;
        // Same-edge tc and ovf_clr
        load_val(MAXV);
        cnt_if.ovf_clr_i = 1; cycles(1); cnt_if.ovf_clr_i = 0;
        cycles(5);

        // Asynchronous reset mid-count
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 check("async_reset", 64'(sample()), 64'(rst_exp));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(5);

        // Randomised mixed operation
        for (int i = 0; i < 3000; i++) begin
            cnt_if.en_i      = ($urandom_range(0, 7) != 0);
            cnt_if.clr_i     = ($urandom_range(0, 99) == 0);
            cnt_if.load_i    = ($urandom_range(0, 19) == 0);
            cnt_if.ovf_clr_i = ($urandom_range(0, 15) == 0);
            cnt_if.load_val_i = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 3))
                                                            : W'($urandom_range(MAXV - 3, MAXV));
            if ($urandom_range(0, 3) == 0) cnt_if.load_val_i = W'($urandom());
            if ($urandom_range(0, 31) == 0) cnt_if.dir_i = ~cnt_if.dir_i;
            if ($urandom_range(0, 31) == 0) cnt_if.mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) cnt_if.prescale_i = P'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) cnt_if.cmp_val_i = W'($urandom());
            cycles(1);
        end
        cnt_if.clr_i = 0; cnt_if.load_i = 0; cnt_if.ovf_clr_i = 0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ttes_counter_unit.md
Name: ttes_counter_unit

Overview:
Parametrised general-purpose counter for the TinyTapeout top level. It succeeds the fixed 4-bit free-running counter with:
- configurable width
- programmable prescaler
- up/down direction
- wrap, saturate and one-shot modes
- synchronous load and clear
- compare-match, terminal-count and sticky-overflow flags

The top level instantiates it and maps count/flags onto uo_out, with control driven from ui_in/uio_in.

Parameters:
WIDTH, 8, counter width in bits (>=2)
PSC_W, 4, prescaler compare width; step period = prescale+1 enabled cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; gates the prescaler
clr  in  1  synchronous clear of count, prescaler, flags, state
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value for load
dir  in  1  0 = up, 1 = down
mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
prescale  in  PSC_W  step every prescale+1 enabled cycles
cmp_val  in  WIDTH  compare value
ovf_clr  in  1  clears ovf_sticky
count  out  WIDTH  current count (registered)
tick  out  1  1-cycle pulse: count stepped this edge
match  out  1  1-cycle pulse: step produced count == cmp_val
tc  out  1  1-cycle pulse: step attempted at terminal value
ovf_sticky  out  1  set by any tc event; held until cleared
running  out  1  1 = RUN state, 0 = HALT (one-shot finished)

Behaviour:
- Reset (rst_n low, async): count=0, psc=0, tick=match=tc=ovf_sticky=0, state=RUN (running=1).
- Internal prescaler psc (PSC_W bits):
  - en=1: step_req = (psc >= prescale). On step_req psc<=0, else psc<=psc+1.
  - en=0: psc holds; no step.
  - The >= comparison handles prescale lowered mid-period.
- Terminal value: all-ones when dir=0; 0 when dir=1.
- Priority per edge: clr > load > step.
  - clr: count=0, psc=0, ovf_sticky=0, state=RUN, pulses 0.
  - load: count=load_val, psc=0, state=RUN, tick/match/tc=0, ovf_sticky unchanged.
- Step only occurs when state=RUN and step_req:
  - Not at terminal: count +/- 1, tick=1, match=(new count == cmp_val).
  - At terminal, wrap: count wraps (255->0 / 0->255 for WIDTH=8); tick=1, tc=1, match per new value.
  - At terminal, saturate: count holds, tick=0, tc=1 on every step attempt, match=0.
  - At terminal, one-shot: count holds, tc=1 once, state->HALT, tick=0.
- HALT:
  - No steps, no pulses; psc continues to run but is ignored.
  - Exits to RUN on load, clr, or mode != 10 (next edge).
- Pulse timing: tick/match/tc are registered and high in the same cycle the updated count is visible. Latency is one edge from the cycle step_req is true.
- ovf_sticky: set on any tc; cleared by ovf_clr. Set wins if tc and ovf_clr occur on the same edge.
- dir, mode, cmp_val and prescale are sampled every edge; changes take effect on the next step decision. No glitch or state corruption on mid-run changes.
- match is not generated by load, even when load_val == cmp_val.
- Async reset mid-operation returns everything to reset values immediately.

Test Plan:
1. WIDTH=8, prescale=0, up, wrap, en=1 after reset -> count 1,2,...,255,0 on successive cycles; tick high every cycle; tc and ovf_sticky rise on the 255->0 edge; ovf_clr=1 then clears ovf_sticky.
2. prescale=3, up, en=1 -> tick every 4th cycle (count 0->1 on cycle 4). With en low for 2 cycles mid-period, the next tick is delayed by exactly 2 cycles.
3. saturate, dir=1, load 3, prescale=0 -> count 2,1,0,0,0; tick only on the three real steps; tc pulses on each attempt at 0; ovf_sticky=1.
4. one-shot, up, load 250 -> count 251..255, then one tc pulse, running=0, count holds 255 for 10 cycles with no pulses; load 10 -> running=1 and counting resumes at 11.
5. cmp_val=0x10, up from 0x0C -> match pulses once on the 0x0F->0x10 step; load 0x10 produces no match; wrap back through 0x10 matches again.
6. Same-edge clr+load+step_req -> count=0, ovf_sticky=0, no pulses. Same-edge tc and ovf_clr -> ovf_sticky stays 1. rst_n low mid-count -> immediate count=0, running=1.
